// File: rtl/blink_round_ctrl.sv
// Blink game challenge controller: LFSR target, blink show, checker handshake, scoring.
// Optional BLINK_DEBOUNCE_EN adds a stable-level debouncer on the synchronized button.
module blink_round_ctrl #(
    parameter int unsigned BLINK_CYCLES    = 25_000_000,
    parameter int unsigned SHOW_BLINKS     = 3,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    output logic [15:0] led,
    output logic [15:0] target,
    output logic        check_req,
    input  logic        result_valid,
    input  logic        result_ok,
    output logic [7:0]  score,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHOW   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [15:0] SEED_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(2 * BLINK_CYCLES - 1);
    localparam logic [31:0] PHASE_LAST = 32'(2 * SHOW_BLINKS - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] target_q, target_d;
    logic [7:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic        check_req_q, check_req_d;
    logic        ok_q, ok_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] phase_q, phase_d;
    logic        sync1_q, sync2_q, lvl_prev_q;
    logic        btn_lvl;
    logic        press;
    logic [15:0] lfsr_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            lvl_prev_q <= btn_lvl;
        end
    end

`ifdef BLINK_DEBOUNCE_EN
    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

    logic        db_lvl_q;
    logic [31:0] db_cnt_q;

    // Level is accepted once it has differed from the current debounced level for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
        end else if (sync2_q == db_lvl_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_lvl_q <= sync2_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 32'd1;
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign btn_lvl             = sync2_q;
`endif

    assign press    = btn_lvl & ~lvl_prev_q;
    assign lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        target_d    = target_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        check_req_d = 1'b0;
        ok_d        = ok_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d     = S_SHOW;
                    lfsr_d      = lfsr_adv;
                    target_d    = lfsr_adv;
                    score_d     = '0;
                    game_over_d = 1'b0;
                    cnt_d       = '0;
                    phase_d     = '0;
                end
            end
            S_SHOW: begin
                if (cnt_q == BLINK_LAST) begin
                    cnt_d = '0;
                    if (phase_q == PHASE_LAST) begin
                        state_d = S_WAIT;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT: begin
                if (press) begin
                    state_d     = S_CHECK;
                    check_req_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (result_valid) begin
                    state_d = S_RESULT;
                    ok_d    = result_ok;
                    cnt_d   = '0;
                    if (result_ok && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                    end
                end
            end
            S_RESULT: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (ok_q) begin
                        state_d  = S_SHOW;
                        lfsr_d   = lfsr_adv;
                        target_d = lfsr_adv;
                        phase_d  = '0;
                    end else begin
                        state_d     = S_IDLE;
                        game_over_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_INIT;
            target_q    <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            check_req_q <= 1'b0;
            ok_q        <= 1'b0;
            cnt_q       <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            target_q    <= target_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            check_req_q <= check_req_d;
            ok_q        <= ok_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Even phases are the on-phases of the blink sequence.
    always_comb begin
        led = '0;
        case (state_q)
            S_SHOW:   led = phase_q[0] ? 16'h0000 : target_q;
            S_RESULT: led = ok_q ? 16'hFFFF : 16'h8001;
            default:  led = '0;
        endcase
    end

    assign target    = target_q;
    assign check_req = check_req_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_blink_round_ctrl.sv
// Scoreboard bench: stimulus queues expected output runs (value + length), a monitor compares each completed run.
module tb_blink_round_ctrl;

    typedef struct packed {
        logic [15:0] led;
        logic [15:0] tgt;
        logic [7:0]  score;
        logic        go;
        logic        creq;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        btn;
    logic [15:0] led;
    logic [15:0] target;
    logic        check_req;
    logic        result_valid;
    logic        result_ok;
    logic [7:0]  score;
    logic        game_over;

    logic rv_stim, rv_resp, rok_resp;
    bit   flush_req, flushed;

    int checks, errors;
    int run_idx;

    obs_t        exp_o[$];
    int unsigned exp_len[$];
    bit          verdict_q[$];

    assign result_valid = rv_stim | rv_resp;
    assign result_ok    = rv_resp ? rok_resp : 1'b1;

    blink_round_ctrl #(
        .BLINK_CYCLES(4),
        .SHOW_BLINKS (2),
        .SEED        (16'h0001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .led         (led),
        .target      (target),
        .check_req   (check_req),
        .result_valid(result_valid),
        .result_ok   (result_ok),
        .score       (score),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_run(input logic [15:0] l, input logic [15:0] t, input logic [7:0] s,
                              input logic g, input logic r, input int unsigned n);
        obs_t o;
        o.led = l; o.tgt = t; o.score = s; o.go = g; o.creq = r;
        exp_o.push_back(o);
        exp_len.push_back(n);
    endtask

    task automatic close_run(input obs_t run, input int unsigned len);
        obs_t        e;
        int unsigned n;
        checks++;
        run_idx++;
        if (exp_o.size() == 0) begin
            errors++;
            $display("FAIL run%0d unexpected: got led=%h tgt=%h score=%0d go=%b req=%b len=%0d, none required",
                     run_idx, run.led, run.tgt, run.score, run.go, run.creq, len);
        end else begin
            e = exp_o.pop_front();
            n = exp_len.pop_front();
            if (run !== e || (n != 0 && len != n)) begin
                errors++;
                $display("FAIL run%0d: got led=%h tgt=%h score=%0d go=%b req=%b len=%0d, required led=%h tgt=%h score=%0d go=%b req=%b len=%0d",
                         run_idx, run.led, run.tgt, run.score, run.go, run.creq, len,
                         e.led, e.tgt, e.score, e.go, e.creq, n);
            end
        end
    endtask

    task automatic press();
        @(posedge clk); #1 btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn = 1'b0;
    endtask

    // Monitor: an output event is any change of the observed tuple; the finished run is checked.
    initial begin : monitor
        obs_t        cur, run;
        int unsigned len;
        bit          have;
        have = 1'b0; len = 0; run = '0;
        while (!flushed) begin
            @(negedge clk);
            cur = {led, target, score, game_over, check_req};
            if (flush_req) begin
                close_run(run, len);
                checks++;
                if (exp_o.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_runs: got %0d pending, required 0", exp_o.size());
                end
                flushed = 1'b1;
            end else if (!have) begin
                run = cur; len = 1; have = 1'b1;
            end else if (cur === run) begin
                len++;
            end else begin
                close_run(run, len);
                run = cur; len = 1;
            end
        end
    end

    // Checker model: answers each check_req two cycles later with the queued verdict.
    initial begin : responder
        bit ok;
        rv_resp = 1'b0; rok_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (check_req === 1'b1) begin
                ok = (verdict_q.size() != 0) ? verdict_q.pop_front() : 1'b0;
                @(posedge clk); #1 rv_resp = 1'b1; rok_resp = ok;
                @(posedge clk); #1 rv_resp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not complete, required completion before 100000 ns");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stimulus
        checks = 0; errors = 0; run_idx = 0;
        flush_req = 1'b0; flushed = 1'b0;
        rst_n = 1'b0; btn = 1'b0; rv_stim = 1'b0;

        // Reset and idle
        expect_run(16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);

        // Round 1: blink B400, extra press during SHOW and stray verdict in WAIT ignored
        expect_run(16'hB400, 16'hB400, 8'd0, 1'b0, 1'b0, 4);
        expect_run(16'h0000, 16'hB400, 8'd0, 1'b0, 1'b0, 4);
        expect_run(16'hB400, 16'hB400, 8'd0, 1'b0, 1'b0, 4);
        expect_run(16'h0000, 16'hB400, 8'd0, 1'b0, 1'b0, 0);
        press();
        repeat (3) @(posedge clk);
        press();
        repeat (12) @(posedge clk);
        @(posedge clk); #1 rv_stim = 1'b1;
        @(posedge clk); #1 rv_stim = 1'b0;
        repeat (3) @(posedge clk);

        // Submit, pass, next round 5A00
        verdict_q.push_back(1'b1);
        expect_run(16'h0000, 16'hB400, 8'd0, 1'b0, 1'b1, 1);
        expect_run(16'h0000, 16'hB400, 8'd0, 1'b0, 1'b0, 1);
        expect_run(16'hFFFF, 16'hB400, 8'd1, 1'b0, 1'b0, 8);
        expect_run(16'h5A00, 16'h5A00, 8'd1, 1'b0, 1'b0, 4);
        expect_run(16'h0000, 16'h5A00, 8'd1, 1'b0, 1'b0, 4);
        expect_run(16'h5A00, 16'h5A00, 8'd1, 1'b0, 1'b0, 4);
        expect_run(16'h0000, 16'h5A00, 8'd1, 1'b0, 1'b0, 0);
        press();
        repeat (35) @(posedge clk);

        // Submit, fail, game over with score held
        verdict_q.push_back(1'b0);
        expect_run(16'h0000, 16'h5A00, 8'd1, 1'b0, 1'b1, 1);
        expect_run(16'h0000, 16'h5A00, 8'd1, 1'b0, 1'b0, 1);
        expect_run(16'h8001, 16'h5A00, 8'd1, 1'b0, 1'b0, 8);
        expect_run(16'h0000, 16'h5A00, 8'd1, 1'b1, 1'b0, 0);
        press();
        repeat (20) @(posedge clk);

        // New game clears score/game_over, then reset mid-SHOW
        expect_run(16'h2D00, 16'h2D00, 8'd0, 1'b0, 1'b0, 0);
        expect_run(16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 0);
        press();
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({led, target, score, game_over, check_req} !== 42'd0) begin
            errors++;
            $display("FAIL async_reset: got led=%h tgt=%h score=%0d go=%b req=%b, required all zero",
                     led, target, score, game_over, check_req);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // LFSR restarts from the seed
        expect_run(16'hB400, 16'hB400, 8'd0, 1'b0, 1'b0, 4);
        expect_run(16'h0000, 16'hB400, 8'd0, 1'b0, 1'b0, 4);
        expect_run(16'hB400, 16'hB400, 8'd0, 1'b0, 1'b0, 4);
        expect_run(16'h0000, 16'hB400, 8'd0, 1'b0, 1'b0, 0);
        press();
        repeat (25) @(posedge clk);

        flush_req = 1'b1;
        repeat (3) @(posedge clk);
        checks++;
        if (!flushed) begin
            errors++;
            $display("FAIL monitor_flush: got flushed=0, required 1");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
